// File: rtl/tdm_demux_1bit.sv
// Receiver for a 1-bit TDM link: tracks frame alignment, gathers one frame of
// channel bits and publishes them in parallel, atomically, once per good frame.
module tdm_demux_1bit #(
  parameter int unsigned N_CH = 4,
  localparam int unsigned SW = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            strobe,
  input  logic            frame,
  input  logic            din,
  output logic [N_CH-1:0] dout,
  output logic            dout_valid,
  output logic [SW-1:0]   slot,
  output logic            locked,
  output logic            sync_err
);

  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_n;
  logic [SW-1:0]     slot_n;
  logic [N_CH-2:0]   shadow_q;
  logic [N_CH-2:0]   shadow_n;
  logic [N_CH-1:0]   dout_n;
  logic              dout_valid_n;
  logic              sync_err_n;

  // State, slot counter, shadow frame and all outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      slot       <= '0;
      shadow_q   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_n;
      slot       <= slot_n;
      shadow_q   <= shadow_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      sync_err   <= sync_err_n;
      locked     <= (state_n == LOCK);
    end
  end

  // Alignment FSM: only a strobe advances anything; pulses default low
  always_comb begin
    state_n      = state_q;
    slot_n       = slot;
    shadow_n     = shadow_q;
    dout_n       = dout;
    dout_valid_n = 1'b0;
    sync_err_n   = 1'b0;

    if (strobe) begin
      case (state_q)
        HUNT: begin
          slot_n = '0;
          if (frame) begin
            shadow_n[0] = din;
            slot_n      = SW'(1);
            state_n     = LOCK;
          end
        end

        LOCK: begin
          if (frame) begin
            // A marker mid-frame restarts the frame from this sample
            if (slot != '0) sync_err_n = 1'b1;
            shadow_n[0] = din;
            slot_n      = SW'(1);
          end else if (slot == '0) begin
            // Missing marker: alignment lost
            sync_err_n = 1'b1;
            state_n    = HUNT;
          end else if (slot == LAST_SLOT) begin
            dout_n       = {din, shadow_q};
            dout_valid_n = 1'b1;
            slot_n       = '0;
          end else begin
            for (int k = 1; k < int'(N_CH) - 1; k++) begin
              if (slot == SW'(k)) shadow_n[k] = din;
            end
            slot_n = slot + SW'(1);
          end
        end

        default: begin
          state_n = HUNT;
          slot_n  = '0;
        end
      endcase
    end
  end

endmodule
